// File: rtl/fp_to_decimal_sci.sv
// fp_to_decimal_sci: iterative IEEE-754 single -> decimal scientific converter.
// The operand is expanded into a wide exact fixed-point value (150 fraction
// bits cover the smallest normal, 128 integer bits cover the largest), scaled
// by 10 until it lies in [1,10), then six fraction digits are peeled off.
//
// state    | meaning
// S_IDLE   | compare input against latched copy, start on change / first cycle
// S_CHECK  | classify zero/denormal, Inf, NaN; otherwise load fixed-point value
// S_NORM   | multiply or divide by 10 until 1 <= value < 10
// S_DIGITS | six fraction x10 steps accumulating the fractional digits
// S_DONE   | publish sign/digit, fraction and exponent together
module fp_to_decimal_sci (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] in,
  output logic [4:0]  nguyen,
  output logic [19:0] le,
  output logic [8:0]  lt
);

  localparam int FRAC_W = 150;
  localparam int VAL_W  = 278;
  localparam int INT_W  = VAL_W - FRAC_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_NORM   = 3'd2,
    S_DIGITS = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        in_lat_q, in_lat_d;
  logic               first_q, first_d;
  logic [VAL_W-1:0]   v_q, v_d;
  logic               sign_q, sign_d;
  logic [3:0]         digit_q, digit_d;
  logic [19:0]        acc_q, acc_d;
  logic [8:0]         exp10_q, exp10_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [4:0]         nguyen_q, nguyen_d;
  logic [19:0]        le_q, le_d;
  logic [8:0]         lt_q, lt_d;

  logic [INT_W-1:0]   int_part;
  logic               is_small, is_big;
  logic [VAL_W-1:0]   v_mul, v_div;
  logic [FRAC_W+3:0]  frac_ext, fx10;
  logic               start;
  logic               exp_zero, exp_max;

  assign nguyen = nguyen_q;
  assign le     = le_q;
  assign lt     = lt_q;

  assign int_part = v_q[VAL_W-1:FRAC_W];
  assign is_small = (int_part == '0);
  assign is_big   = (int_part > INT_W'(9));
  // multiply only happens while value < 1, so the shifted sum cannot overflow
  assign v_mul    = (v_q << 3) + (v_q << 1);
  assign v_div    = v_q / VAL_W'(10);
  assign frac_ext = {4'b0, v_q[FRAC_W-1:0]};
  assign fx10     = (frac_ext << 3) + (frac_ext << 1);
  assign start    = first_q || (in != in_lat_q);
  assign exp_zero = (in_lat_q[30:23] == 8'h00);
  assign exp_max  = (in_lat_q[30:23] == 8'hFF);

  // state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_CHECK;
      S_CHECK:  state_d = (exp_zero || exp_max) ? S_DONE : S_NORM;
      S_NORM:   if (!is_small && !is_big) state_d = S_DIGITS;
      S_DIGITS: if (cnt_q == 3'd1) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // datapath next values driven by the current state
  always_comb begin
    in_lat_d = in_lat_q;
    first_d  = first_q;
    v_d      = v_q;
    sign_d   = sign_q;
    digit_d  = digit_q;
    acc_d    = acc_q;
    exp10_d  = exp10_q;
    cnt_d    = cnt_q;
    nguyen_d = nguyen_q;
    le_d     = le_q;
    lt_d     = lt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          in_lat_d = in;
          first_d  = 1'b0;
        end
      end
      S_CHECK: begin
        sign_d  = in_lat_q[31];
        acc_d   = '0;
        exp10_d = '0;
        if (exp_zero) begin
          digit_d = 4'h0;
        end else if (exp_max) begin
          digit_d = (in_lat_q[22:0] == 23'd0) ? 4'hF : 4'hE;
        end else begin
          // value = 1.frac * 2^(exp-127), LSB of the fraction field at 2^(exp-150)
          v_d = {{(VAL_W-24){1'b0}}, 1'b1, in_lat_q[22:0]} << in_lat_q[30:23];
        end
      end
      S_NORM: begin
        if (is_small) begin
          v_d     = v_mul;
          exp10_d = exp10_q - 9'd1;
        end else if (is_big) begin
          v_d     = v_div;
          exp10_d = exp10_q + 9'd1;
        end else begin
          digit_d = v_q[FRAC_W+3:FRAC_W];
          v_d     = {{INT_W{1'b0}}, v_q[FRAC_W-1:0]};
          cnt_d   = 3'd6;
        end
      end
      S_DIGITS: begin
        v_d   = {{INT_W{1'b0}}, fx10[FRAC_W-1:0]};
        acc_d = (acc_q * 20'd10) + {16'b0, fx10[FRAC_W+3:FRAC_W]};
        cnt_d = cnt_q - 3'd1;
      end
      S_DONE: begin
        nguyen_d = {sign_q, digit_q};
        le_d     = acc_q;
        lt_d     = exp10_q;
      end
      default: ;
    endcase
  end

  // datapath and output registers; first_q comes out of reset set
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      in_lat_q <= '0;
      first_q  <= 1'b1;
      v_q      <= '0;
      sign_q   <= 1'b0;
      digit_q  <= '0;
      acc_q    <= '0;
      exp10_q  <= '0;
      cnt_q    <= '0;
      nguyen_q <= '0;
      le_q     <= '0;
      lt_q     <= '0;
    end else begin
      in_lat_q <= in_lat_d;
      first_q  <= first_d;
      v_q      <= v_d;
      sign_q   <= sign_d;
      digit_q  <= digit_d;
      acc_q    <= acc_d;
      exp10_q  <= exp10_d;
      cnt_q    <= cnt_d;
      nguyen_q <= nguyen_d;
      le_q     <= le_d;
      lt_q     <= lt_d;
    end
  end

endmodule

// File: tb/tb_fp_to_decimal_sci.sv
// Directed bench for fp_to_decimal_sci with hand-computed decimal results.
module tb_fp_to_decimal_sci;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] in;
  logic [4:0]  nguyen;
  logic [19:0] le;
  logic [8:0]  lt;

  int checks = 0;
  int errors = 0;

  fp_to_decimal_sci dut (
    .CLK    (CLK),
    .RST    (RST),
    .in     (in),
    .nguyen (nguyen),
    .le     (le),
    .lt     (lt)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_outs(input string tag, input logic [4:0] en, input logic [19:0] el,
                            input logic [8:0] et);
    check_val({tag, "_nguyen"}, {59'b0, nguyen}, {59'b0, en});
    check_val({tag, "_le"},     {44'b0, le},     {44'b0, el});
    check_val({tag, "_lt"},     {55'b0, lt},     {55'b0, et});
  endtask

  // drive a new operand, wait (bounded) for the expected result, then confirm it holds
  task automatic run_vec(input string tag, input logic [31:0] val, input int budget,
                         input logic [4:0] en, input logic [19:0] el, input logic [8:0] et);
    int n;
    @(negedge CLK);
    in = val;
    n = 0;
    do begin
      @(posedge CLK);
      #1;
      n++;
    end while (n < budget && !(nguyen === en && le === el && lt === et));
    check_outs(tag, en, el, et);
    repeat (10) @(posedge CLK);
    #1;
    check_val({tag, "_hold"}, {30'b0, nguyen, le, lt}, {30'b0, en, el, et});
  endtask

  initial begin
    RST = 1'b1;
    in  = 32'h3CF5C28F;
    repeat (3) @(posedge CLK);
    #1;
    check_outs("reset", 5'h00, 20'd0, 9'h000);
    @(negedge CLK);
    RST = 1'b0;
    repeat (3000) @(posedge CLK);
    #1;
    check_outs("p03", 5'h02, 20'd999999, 9'h1FE);

    run_vec("one",     32'h3F800000, 202, 5'h01, 20'd0,      9'h000);
    run_vec("m12p5",   32'hC1480000, 202, 5'h11, 20'd250000, 9'h001);
    run_vec("e10",     32'h501502F9, 202, 5'h01, 20'd0,      9'h00A);
    run_vec("negzero", 32'h80000000, 5,   5'h10, 20'd0,      9'h000);
    run_vec("pinf",    32'h7F800000, 5,   5'h0F, 20'd0,      9'h000);
    run_vec("nan",     32'h7FC00000, 5,   5'h0E, 20'd0,      9'h000);
    run_vec("ten",     32'h41200000, 202, 5'h01, 20'd0,      9'h001);
    run_vec("p9p5",    32'h41180000, 202, 5'h09, 20'd500000, 9'h000);
    run_vec("half",    32'h3F000000, 202, 5'h05, 20'd0,      9'h1FF);
    run_vec("denorm",  32'h00400000, 5,   5'h00, 20'd0,      9'h000);
    run_vec("fltmax",  32'h7F7FFFFF, 202, 5'h03, 20'd402823, 9'h026);
    run_vec("ninf",    32'hFF800000, 5,   5'h1F, 20'd0,      9'h000);

    // reset in the middle of a 0.03 conversion
    @(negedge CLK);
    in = 32'h3CF5C28F;
    repeat (4) @(posedge CLK);
    #1;
    check_outs("midrun", 5'h1F, 20'd0, 9'h000);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check_outs("rst_async", 5'h00, 20'd0, 9'h000);
    repeat (2) @(posedge CLK);
    #1;
    check_outs("rst_held", 5'h00, 20'd0, 9'h000);
    @(negedge CLK);
    RST = 1'b0;
    run_vec("p03_rerun", 32'h3CF5C28F, 200, 5'h02, 20'd999999, 9'h1FE);

    // operand change while a conversion is in flight
    @(negedge CLK);
    in = 32'hC1480000;
    repeat (3) @(posedge CLK);
    run_vec("chg_one", 32'h3F800000, 400, 5'h01, 20'd0, 9'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
